alu2_sequencer: RTL and testbench
=================================

ALU2_SEQUENCER -- requirements
Module: alu2_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth; SHALL be a power of 2 in 2..8.
REQ-002 Parameter ALU_WAIT, default 1, cycles from driving ALU inputs to sampling alu_result; SHALL be in 1..7.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_ready  output  1  queue can accept; transfer when cmd_valid & cmd_ready at a rising edge.
REQ-007 Port cmd_a / cmd_b  input  2 each  operands.
REQ-008 Port cmd_op  input  2  operation select (00 add, 01 multiply, 10 nand, 11 not-A).
REQ-009 Port alu_a / alu_b  output  2 each  registered operands driven to the external 2-bit ALU.
REQ-010 Port alu_sel  output  2  registered select driven to the ALU mux.
REQ-011 Port alu_result  input  4  ALU output, sampled by this block.
REQ-012 Port rsp_valid  output  1  response held.
REQ-013 Port rsp_ready  input  1  consumer accepts; transfer when rsp_valid & rsp_ready at a rising edge.
REQ-014 Port rsp_data  output  4  captured alu_result.
REQ-015 Port rsp_op  output  2  op of the response.
REQ-016 Port count  output  4  commands queued (0..FIFO_DEPTH).
REQ-017 Port busy  output  1  high when state is not IDLE or count != 0.

Function
REQ-018 Queue SHALL be a FIFO of {op,a,b} (6 bits) with read/write pointers wrapping modulo FIFO_DEPTH.
REQ-019 cmd_ready SHALL equal (count != FIFO_DEPTH); no combinational path from cmd_valid or rsp_ready to cmd_ready.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and both pointers advanced.
REQ-021 FSM states SHALL be IDLE, WAIT, RESP.
REQ-022 IDLE, count != 0: pop head into alu_a/alu_b/alu_sel, load wait counter with ALU_WAIT, go WAIT.
REQ-023 IDLE, count == 0: hold; alu_* keep last values.
REQ-024 WAIT: decrement counter each cycle; on the edge where counter == 1, register alu_result into rsp_data, alu_sel into rsp_op, set rsp_valid, go RESP.
REQ-025 RESP: rsp_valid, rsp_data, rsp_op SHALL stay stable until the handshake edge.
REQ-026 RESP with rsp_ready high: clear rsp_valid; if count != 0 pop next command and go WAIT in the same edge (back-to-back), else go IDLE.
REQ-027 Latency: command pushed at edge N into an empty idle block SHALL produce rsp_valid high after edge N+1+ALU_WAIT.
REQ-028 Responses SHALL come out in command order; no command dropped or duplicated.
REQ-029 cmd_valid with queue full SHALL be ignored (not stored) until cmd_ready returns.
REQ-030 rsp_data SHALL be alu_result unmodified (no width or sign manipulation).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, pointers 0, count 0, wait counter 0, rsp_valid 0, rsp_data 0, rsp_op 0, alu_a/alu_b/alu_sel 0, busy 0, cmd_ready 1.
REQ-032 Reset during WAIT or RESP SHALL discard the in-flight command and all queued commands; no response emitted after release.
REQ-033 First command accepted SHALL be the first with cmd_valid at a rising edge after rst_n deasserts.

Verification
(Bench ALU model: 00 a+b, 01 a*b, 10 {00,~(a&b)}, 11 {00,~a}, all 4-bit; ALU_WAIT=1, FIFO_DEPTH=4.)
REQ-034 Single op: push {op=00,a=3,b=2} at edge N, rsp_ready=1 -> rsp_valid high after edge N+2, rsp_data=0101, rsp_op=00; busy 0 after the handshake.
REQ-035 Ordering/back-to-back: push mul(3,3), nand(3,1), notA(1,x), rsp_ready=1 -> rsp_data 1001, 0010, 0010 in order, consecutive responses 2 cycles apart.
REQ-036 Full: rsp_ready=0, push 6 commands -> count reaches 4, cmd_ready 0 while 1 in RESP, extra pushes ignored; then rsp_ready=1 drains exactly 5 responses (1 + 4).
REQ-037 Simultaneous push/pop with count=2 -> count stays 2; pointers wrap past 3 to 0 without loss over 10 commands.
REQ-038 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_data/rsp_op stable, alu_* unchanged.
REQ-039 Reset mid-WAIT with 2 queued -> all outputs at REQ-031 values immediately; no rsp_valid after release until a new push.

Source files
------------

// File: rtl/alu2_sequencer.sv
// ---------------------------------------------------------------------------
// alu2_sequencer
//
// Queues {op, a, b} commands and feeds them one at a time to an external
// 2-bit ALU. It waits ALU_WAIT cycles for the ALU to settle, then captures
// the 4-bit result. The result is held as a response until the consumer takes
// it. Responses leave in command order.
//
// Parameters
//   FIFO_DEPTH  command queue depth, power of 2 in 2..8
//   ALU_WAIT    cycles from driving alu_* to sampling alu_result, 1..7
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   queue has room (transfer on cmd_valid & cmd_ready)
//   cmd_a/b     2-bit operands
//   cmd_op      00 add, 01 multiply, 10 nand, 11 not-A
//   alu_a/b     registered operands to the external ALU
//   alu_sel     registered op select to the ALU mux
//   alu_result  4-bit ALU output, sampled here
//   rsp_valid   response held
//   rsp_ready   consumer accepts (transfer on rsp_valid & rsp_ready)
//   rsp_data    captured alu_result, unmodified
//   rsp_op      op of the held response
//   count       commands queued, 0..FIFO_DEPTH
//   busy        sequencer active or commands pending
// ---------------------------------------------------------------------------
module alu2_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_WAIT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_op,
    output logic [3:0] count,
    output logic       busy
);

    localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);
    localparam logic [2:0] WAIT_LOAD = 3'(ALU_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [5:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [2:0]      wait_cnt;

    logic            push;
    logic            pop;
    logic            capture;
    logic            rsp_done;

    // cmd_ready depends only on the registered count, so there is no
    // combinational path from cmd_valid or rsp_ready.
    assign cmd_ready = (count != DEPTH_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || (count != 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. From RESP we go straight back to WAIT when work is
    // queued, so back-to-back commands do not pass through IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != 4'd0) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = (count != 4'd0) ? WAIT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath below.
    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state)
            IDLE: begin
                pop = (count != 4'd0);
            end
            WAIT: begin
                capture = (wait_cnt == 3'd1);
            end
            RESP: begin
                rsp_done = rsp_ready;
                pop      = rsp_ready && (count != 4'd0);
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Queue storage. It needs no reset because entries are only read
    // between the pointers, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Queue pointers and occupancy. The depth is a power of two, so the
    // pointers wrap naturally. A push and a pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // ALU settle counter. It is loaded when a command is issued and counts
    // down in WAIT. The result is captured on the edge where it reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 3'd0;
        end else if (pop) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // ALU operand/select registers. They keep their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= 2'd0;
            alu_b   <= 2'd0;
            alu_sel <= 2'd0;
        end else if (pop) begin
            {alu_sel, alu_a, alu_b} <= fifo_mem[rd_ptr];
        end
    end

    // Response holding registers. They stay stable in RESP until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 4'd0;
            rsp_op    <= 2'd0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_op    <= alu_sel;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu2_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu2_sequencer
//
// Self-checking bench for alu2_sequencer (FIFO_DEPTH=4, ALU_WAIT=1). It models
// the external 2-bit ALU. It pushes an expected {op, result} entry for every
// accepted command, and pops and compares an entry on every response handshake.
// Inputs change on the falling edge. Outputs are sampled shortly after an edge.
// ---------------------------------------------------------------------------
module tb_alu2_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_a;
    logic [1:0] cmd_b;
    logic [1:0] cmd_op;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [1:0] rsp_op;
    logic [3:0] count;
    logic       busy;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   hs_log[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   rsp_cnt    = 0;
    int   rsp_base   = 0;

    // Stimulus tables for the full-queue test (sixth entry must be dropped).
    logic [1:0] full_op [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [1:0] full_a  [6] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] full_b  [6] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1};

    alu2_sequencer #(
        .FIFO_DEPTH (4),
        .ALU_WAIT   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .count      (count),
        .busy       (busy)
    );

    // Reference behaviour of the external ALU.
    function automatic logic [3:0] aluModel(input logic [1:0] op, input logic [1:0] a,
                                            input logic [1:0] b);
        case (op)
            2'd0:    return {2'b00, a} + {2'b00, b};
            2'd1:    return {2'b00, a} * {2'b00, b};
            2'd2:    return {2'b00, ~(a & b)};
            default: return {2'b00, ~a};
        endcase
    endfunction

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle counter used to measure response spacing.
    always @(posedge clk) cycle <= cycle + 1;

    // The external ALU is purely combinational on the registered inputs.
    always_comb alu_result = aluModel(alu_sel, alu_a, alu_b);

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Offer one command, waiting (bounded) for cmd_ready, and record its
    // expected response once the transfer edge is certain.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        int n;
        @(negedge clk);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 8'(cmd_ready), 8'(1));
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back(exp_t'({op, aluModel(op, a, b)}));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen and the DUT is idle.
    task automatic waitDrain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !busy && !rsp_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_left", 8'(sb.size()), 8'(0));
        checkOutput("drain_busy", 8'(busy), 8'(0));
    endtask

    // Response monitor. Inputs are stable here, so valid & ready means the
    // next rising edge is a handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid && rsp_ready) begin
                rsp_cnt++;
                hs_log.push_back(cycle);
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 8'(sb.size()), 8'(1));
                end else begin
                    mon_exp = sb.pop_front();
                    checkOutput("rsp_data", 8'(rsp_data), 8'(mon_exp.data));
                    checkOutput("rsp_op", 8'(rsp_op), 8'(mon_exp.op));
                end
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 2'd0;
        cmd_b     = 2'd0;
        cmd_op    = 2'd0;
        rsp_ready = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'(1));
        checkOutput("rst_rsp_valid", 8'(rsp_valid), 8'(0));
        checkOutput("rst_count", 8'(count), 8'(0));
        checkOutput("rst_busy", 8'(busy), 8'(0));
        checkOutput("rst_alu", 8'({alu_sel, alu_a, alu_b}), 8'(0));
        checkOutput("rst_rsp", 8'({rsp_op, rsp_data}), 8'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Single add with latency check: valid after N+2, not after N+1.
        applyStimulus(2'd0, 2'd3, 2'd2);
        @(posedge clk);
        #1;
        checkOutput("lat_n1_valid", 8'(rsp_valid), 8'(0));
        @(posedge clk);
        #1;
        checkOutput("lat_n2_valid", 8'(rsp_valid), 8'(1));
        checkOutput("single_data", 8'(rsp_data), 8'(4'b0101));
        checkOutput("single_op", 8'(rsp_op), 8'(0));
        @(posedge clk);
        #1;
        checkOutput("single_busy", 8'(busy), 8'(0));
        checkOutput("single_done", 8'(rsp_valid), 8'(0));

        // Ordering and back-to-back spacing.
        hs_log.delete();
        applyStimulus(2'd1, 2'd3, 2'd3);
        applyStimulus(2'd2, 2'd3, 2'd1);
        applyStimulus(2'd3, 2'd1, 2'd2);
        waitDrain(40);
        checkOutput("b2b_count", 8'(hs_log.size()), 8'(3));
        if (hs_log.size() == 3) begin
            checkOutput("b2b_gap1", 8'(hs_log[1] - hs_log[0]), 8'(2));
            checkOutput("b2b_gap2", 8'(hs_log[2] - hs_log[1]), 8'(2));
        end

        // Full queue under backpressure: five accepted, the sixth ignored.
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_op    = full_op[i];
            cmd_a     = full_a[i];
            cmd_b     = full_b[i];
            cmd_valid = 1'b1;
            #1;
            checkOutput("full_ready", 8'(cmd_ready), (i < 5) ? 8'(1) : 8'(0));
            if (i < 5) sb.push_back(exp_t'({full_op[i], aluModel(full_op[i], full_a[i], full_b[i])}));
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        checkOutput("full_count", 8'(count), 8'(4));
        checkOutput("full_cmd_ready", 8'(cmd_ready), 8'(0));

        // Backpressure: response and ALU inputs hold for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 8'(rsp_valid), 8'(1));
            checkOutput("bp_data", 8'(rsp_data), 8'(aluModel(full_op[0], full_a[0], full_b[0])));
            checkOutput("bp_op", 8'(rsp_op), 8'(full_op[0]));
            checkOutput("bp_alu", 8'({alu_sel, alu_a, alu_b}), 8'({full_op[0], full_a[0], full_b[0]}));
        end
        rsp_base = rsp_cnt;
        @(negedge clk);
        rsp_ready = 1'b1;
        waitDrain(60);
        checkOutput("full_drained", 8'(rsp_cnt - rsp_base), 8'(5));

        // Simultaneous push/pop at count 2, then stream through the pointer wrap.
        @(negedge clk);
        rsp_ready = 1'b0;
        rsp_base  = rsp_cnt;
        applyStimulus(2'd0, 2'd1, 2'd2);
        applyStimulus(2'd1, 2'd2, 2'd3);
        applyStimulus(2'd2, 2'd1, 2'd1);
        checkOutput("simul_pre_count", 8'(count), 8'(2));
        checkOutput("simul_pre_valid", 8'(rsp_valid), 8'(1));
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_op    = 2'd3;
        cmd_a     = 2'd2;
        cmd_b     = 2'd0;
        cmd_valid = 1'b1;
        #1;
        checkOutput("simul_ready", 8'(cmd_ready), 8'(1));
        sb.push_back(exp_t'({2'd3, aluModel(2'd3, 2'd2, 2'd0)}));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("simul_count", 8'(count), 8'(2));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'(i), 2'(i + 1), 2'(3 - i));
        end
        waitDrain(80);
        checkOutput("wrap_total", 8'(rsp_cnt - rsp_base), 8'(10));

        // Reset in WAIT with two commands queued.
        applyStimulus(2'd0, 2'd1, 2'd1);
        applyStimulus(2'd1, 2'd2, 2'd2);
        applyStimulus(2'd2, 2'd2, 2'd1);
        applyStimulus(2'd3, 2'd0, 2'd3);
        checkOutput("pre_rst_count", 8'(count), 8'(2));
        checkOutput("pre_rst_busy", 8'(busy), 8'(1));
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("mid_rst_valid", 8'(rsp_valid), 8'(0));
        checkOutput("mid_rst_count", 8'(count), 8'(0));
        checkOutput("mid_rst_busy", 8'(busy), 8'(0));
        checkOutput("mid_rst_ready", 8'(cmd_ready), 8'(1));
        checkOutput("mid_rst_alu", 8'({alu_sel, alu_a, alu_b}), 8'(0));
        checkOutput("mid_rst_rsp", 8'({rsp_op, rsp_data}), 8'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_valid", 8'(rsp_valid), 8'(0));
            checkOutput("post_rst_count", 8'(count), 8'(0));
        end
        rsp_base = rsp_cnt;
        applyStimulus(2'd3, 2'd2, 2'd1);
        waitDrain(40);
        checkOutput("post_rst_rsps", 8'(rsp_cnt - rsp_base), 8'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
